mem_stage: RTL and testbench

- Memory (MEM) pipeline stage, directly downstream of the Execute stage and upstream of Writeback.
- Takes the EX pipeline latch and performs LDB/LDW/STB/STW against an external data-memory port with a request/acknowledge handshake.
- Serves memory-mapped LEDR/HEX registers internally.
- Stalls upstream stages while an external access is outstanding, and forwards register/CC write-enables to Writeback and Decode.

---
 rtl/mem_stage.sv | 360 ++++++++++++++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage between Execute and Writeback.
//
// Performs LDB/LDW/STB/STW against an external data-memory port with a
// req/ack handshake, serves the LEDR/HEX registers in the MMIO window
// internally, stalls upstream while an external access is outstanding,
// and forwards register/CC write-enables to Writeback and Decode.
// All state updates on the falling clock edge, as in the rest of the pipeline.
//
// Ports:
//   I_CLOCK, I_RESET_N        clock (negedge) / synchronous active-low reset
//   I_LOCK, I_EX_Valid        pipeline enable and instruction valid from EX
//   I_PC/I_Opcode/I_IR/...    EX latch fields (dest idx/value, CC, MAR, MDR, WEns)
//   I_DMemRdData, I_DMemAck   external memory response
//   O_*                       registered MEM latch fields to Writeback
//   O_RegWEn_Signal/O_CCWEn_Signal  combinational WEns for DE dependency checks
//   O_MEMStall                freezes the IF/DE/EX latches
//   O_DMem*                   external memory request
//   O_LEDR, O_HEX             MMIO registers
//   O_MemErr                  one-cycle pulse on misaligned word access or timeout
//
// state  | meaning
// IDLE   | accepting instructions; 1-cycle ops complete here
// WAIT   | external access outstanding, request fields held

module mem_stage #(
  parameter int                     DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0]  MMIO_BASE    = 32'hF000_0000,
  parameter int                     ACK_TIMEOUT  = 15,
  parameter int                     PC_WIDTH     = 16,
  parameter int                     OPCODE_WIDTH = 8,
  parameter int                     IR_WIDTH     = 32,
  parameter logic [OPCODE_WIDTH-1:0] OP_LDB      = 8'h20,
  parameter logic [OPCODE_WIDTH-1:0] OP_LDW      = 8'h21,
  parameter logic [OPCODE_WIDTH-1:0] OP_STB      = 8'h22,
  parameter logic [OPCODE_WIDTH-1:0] OP_STW      = 8'h23
) (
  input  logic                    I_CLOCK,
  input  logic                    I_RESET_N,
  input  logic                    I_LOCK,
  input  logic [PC_WIDTH-1:0]     I_PC,
  input  logic [OPCODE_WIDTH-1:0] I_Opcode,
  input  logic [IR_WIDTH-1:0]     I_IR,
  input  logic [3:0]              I_DestRegIdx,
  input  logic [DATA_WIDTH-1:0]   I_DestValue,
  input  logic [2:0]              I_CCValue,
  input  logic                    I_EX_Valid,
  input  logic [DATA_WIDTH-1:0]   I_MARValue,
  input  logic [DATA_WIDTH-1:0]   I_MDRValue,
  input  logic                    I_RegWEn,
  input  logic                    I_CCWEn,
  input  logic [DATA_WIDTH-1:0]   I_DMemRdData,
  input  logic                    I_DMemAck,
  output logic                    O_LOCK,
  output logic [OPCODE_WIDTH-1:0] O_Opcode,
  output logic [PC_WIDTH-1:0]     O_PC,
  output logic [IR_WIDTH-1:0]     O_IR,
  output logic [3:0]              O_DestRegIdx,
  output logic [DATA_WIDTH-1:0]   O_DestValue,
  output logic [2:0]              O_CCValue,
  output logic                    O_MEM_Valid,
  output logic                    O_RegWEn,
  output logic                    O_CCWEn,
  output logic                    O_RegWEn_Signal,
  output logic                    O_CCWEn_Signal,
  output logic                    O_MEMStall,
  output logic                    O_DMemReq,
  output logic [DATA_WIDTH-1:0]   O_DMemAddr,
  output logic                    O_DMemWrEn,
  output logic [3:0]              O_DMemByteEn,
  output logic [DATA_WIDTH-1:0]   O_DMemWrData,
  output logic [9:0]              O_LEDR,
  output logic [15:0]             O_HEX,
  output logic                    O_MemErr
);

  localparam int                    CNT_W       = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]      TIMEOUT_CNT = CNT_W'(ACK_TIMEOUT);
  localparam logic [DATA_WIDTH-1:0] LEDR_ADDR   = MMIO_BASE;
  localparam logic [DATA_WIDTH-1:0] HEX_ADDR    = MMIO_BASE + DATA_WIDTH'(4);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic                    lock_q, lock_d;
  logic [PC_WIDTH-1:0]     pc_q, pc_d;
  logic [OPCODE_WIDTH-1:0] opc_q, opc_d;
  logic [IR_WIDTH-1:0]     ir_q, ir_d;
  logic [3:0]              idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   dval_q, dval_d;
  logic [2:0]              cc_q, cc_d;
  logic                    valid_q, valid_d;
  logic                    regwen_q, regwen_d;
  logic                    ccwen_q, ccwen_d;
  logic                    err_q, err_d;
  logic [9:0]              ledr_q, ledr_d;
  logic [15:0]             hex_q, hex_d;

  // Holding registers for the outstanding external access
  logic [DATA_WIDTH-1:0]   h_addr_q, h_addr_d;
  logic [DATA_WIDTH-1:0]   h_wdata_q, h_wdata_d;
  logic [3:0]              h_be_q, h_be_d;
  logic                    h_wren_q, h_wren_d;
  logic                    h_byte_q, h_byte_d;
  logic                    h_load_q, h_load_d;
  logic [1:0]              h_off_q, h_off_d;
  logic                    h_regwen_q, h_regwen_d;
  logic                    h_ccwen_q, h_ccwen_d;
  logic                    h_misalign_q, h_misalign_d;

  // Decode of the incoming EX latch
  logic                    is_ldb, is_ldw, is_stb, is_stw;
  logic                    is_load, is_store, is_byte;
  logic                    mem_op, is_mmio, ext_op, in_misalign;
  logic [1:0]              in_off;
  logic [DATA_WIDTH-1:0]   in_addr, in_wdata, mmio_rdata;
  logic [3:0]              in_be;

  function automatic logic [DATA_WIDTH-1:0] load_value(
    input logic [DATA_WIDTH-1:0] word,
    input logic                  byte_op,
    input logic [1:0]            off
  );
    logic [DATA_WIDTH-1:0] v;
    v = word;
    if (byte_op) begin
      v = '0;
      case (off)
        2'd0:    v[7:0] = word[7:0];
        2'd1:    v[7:0] = word[15:8];
        2'd2:    v[7:0] = word[23:16];
        default: v[7:0] = word[31:24];
      endcase
    end
    return v;
  endfunction

  assign is_ldb      = (I_Opcode == OP_LDB);
  assign is_ldw      = (I_Opcode == OP_LDW);
  assign is_stb      = (I_Opcode == OP_STB);
  assign is_stw      = (I_Opcode == OP_STW);
  assign is_load     = is_ldb | is_ldw;
  assign is_store    = is_stb | is_stw;
  assign is_byte     = is_ldb | is_stb;
  assign mem_op      = I_LOCK & I_EX_Valid & (is_load | is_store);
  assign is_mmio     = (I_MARValue >= MMIO_BASE);
  assign ext_op      = mem_op & ~is_mmio;
  assign in_off      = I_MARValue[1:0];
  assign in_addr     = {I_MARValue[DATA_WIDTH-1:2], 2'b00};
  assign in_be       = is_byte ? (4'b0001 << in_off) : 4'b1111;
  assign in_wdata    = is_stb ? {4{I_MDRValue[7:0]}} : I_MDRValue;
  // Word accesses ignore the low address bits but still flag the error
  assign in_misalign = ~is_byte & (in_off != 2'b00);

  always_comb begin
    mmio_rdata = '0;
    if (in_addr == LEDR_ADDR) begin
      mmio_rdata[9:0] = ledr_q;
    end else if (in_addr == HEX_ADDR) begin
      mmio_rdata[15:0] = hex_q;
    end
  end

  assign O_RegWEn_Signal = I_EX_Valid & I_RegWEn;
  assign O_CCWEn_Signal  = I_EX_Valid & I_CCWEn;

  // While I_LOCK is low in WAIT the access is frozen: request withdrawn,
  // stall kept so EX does not move on.
  assign O_MEMStall   = (state_q == S_WAIT) | (ext_op & ~I_DMemAck);
  assign O_DMemReq    = (state_q == S_WAIT) ? I_LOCK       : ext_op;
  assign O_DMemAddr   = (state_q == S_WAIT) ? h_addr_q     : in_addr;
  assign O_DMemWrEn   = (state_q == S_WAIT) ? h_wren_q     : (ext_op & is_store);
  assign O_DMemByteEn = (state_q == S_WAIT) ? h_be_q       : in_be;
  assign O_DMemWrData = (state_q == S_WAIT) ? h_wdata_q    : in_wdata;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lock_d       = I_LOCK;
    pc_d         = pc_q;
    opc_d        = opc_q;
    ir_d         = ir_q;
    idx_d        = idx_q;
    dval_d       = dval_q;
    cc_d         = cc_q;
    valid_d      = 1'b0;
    regwen_d     = 1'b0;
    ccwen_d      = 1'b0;
    err_d        = 1'b0;
    ledr_d       = ledr_q;
    hex_d        = hex_q;
    h_addr_d     = h_addr_q;
    h_wdata_d    = h_wdata_q;
    h_be_d       = h_be_q;
    h_wren_d     = h_wren_q;
    h_byte_d     = h_byte_q;
    h_load_d     = h_load_q;
    h_off_d      = h_off_q;
    h_regwen_d   = h_regwen_q;
    h_ccwen_d    = h_ccwen_q;
    h_misalign_d = h_misalign_q;

    case (state_q)
      S_IDLE: begin
        // Latch fields follow EX; they stay frozen through WAIT
        pc_d   = I_PC;
        opc_d  = I_Opcode;
        ir_d   = I_IR;
        idx_d  = I_DestRegIdx;
        cc_d   = I_CCValue;
        dval_d = I_DestValue;
        if (I_LOCK) begin
          if (!mem_op) begin
            valid_d  = I_EX_Valid;
            regwen_d = I_EX_Valid & I_RegWEn;
            ccwen_d  = I_EX_Valid & I_CCWEn;
          end else if (is_mmio) begin
            valid_d  = 1'b1;
            regwen_d = I_RegWEn & is_load;
            ccwen_d  = I_CCWEn;
            err_d    = in_misalign;
            if (is_load) begin
              dval_d = load_value(mmio_rdata, is_byte, in_off);
            end else if (in_addr == LEDR_ADDR) begin
              ledr_d = I_MDRValue[9:0];
            end else if (in_addr == HEX_ADDR) begin
              hex_d = I_MDRValue[15:0];
            end
          end else if (I_DMemAck) begin
            valid_d  = 1'b1;
            regwen_d = I_RegWEn & is_load;
            ccwen_d  = I_CCWEn;
            err_d    = in_misalign;
            if (is_load) begin
              dval_d = load_value(I_DMemRdData, is_byte, in_off);
            end
          end else begin
            state_d      = S_WAIT;
            // The issuing cycle already counts toward the timeout
            cnt_d        = CNT_W'(1);
            h_addr_d     = in_addr;
            h_wdata_d    = in_wdata;
            h_be_d       = in_be;
            h_wren_d     = is_store;
            h_byte_d     = is_byte;
            h_load_d     = is_load;
            h_off_d      = in_off;
            h_regwen_d   = I_RegWEn & is_load;
            h_ccwen_d    = I_CCWEn;
            h_misalign_d = in_misalign;
          end
        end
      end

      S_WAIT: begin
        if (I_LOCK) begin
          if (I_DMemAck) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            valid_d  = 1'b1;
            regwen_d = h_regwen_q;
            ccwen_d  = h_ccwen_q;
            err_d    = h_misalign_q;
            if (h_load_q) begin
              dval_d = load_value(I_DMemRdData, h_byte_q, h_off_q);
            end
          end else if ((cnt_q + CNT_W'(1)) == TIMEOUT_CNT) begin
            // Abandoned access retires with no architectural update
            state_d = S_IDLE;
            cnt_d   = '0;
            valid_d = 1'b1;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(negedge I_CLOCK) begin
    if (!I_RESET_N) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      lock_q       <= 1'b0;
      pc_q         <= '0;
      opc_q        <= '0;
      ir_q         <= '0;
      idx_q        <= '0;
      dval_q       <= '0;
      cc_q         <= '0;
      valid_q      <= 1'b0;
      regwen_q     <= 1'b0;
      ccwen_q      <= 1'b0;
      err_q        <= 1'b0;
      ledr_q       <= '0;
      hex_q        <= '0;
      h_addr_q     <= '0;
      h_wdata_q    <= '0;
      h_be_q       <= '0;
      h_wren_q     <= 1'b0;
      h_byte_q     <= 1'b0;
      h_load_q     <= 1'b0;
      h_off_q      <= '0;
      h_regwen_q   <= 1'b0;
      h_ccwen_q    <= 1'b0;
      h_misalign_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lock_q       <= lock_d;
      pc_q         <= pc_d;
      opc_q        <= opc_d;
      ir_q         <= ir_d;
      idx_q        <= idx_d;
      dval_q       <= dval_d;
      cc_q         <= cc_d;
      valid_q      <= valid_d;
      regwen_q     <= regwen_d;
      ccwen_q      <= ccwen_d;
      err_q        <= err_d;
      ledr_q       <= ledr_d;
      hex_q        <= hex_d;
      h_addr_q     <= h_addr_d;
      h_wdata_q    <= h_wdata_d;
      h_be_q       <= h_be_d;
      h_wren_q     <= h_wren_d;
      h_byte_q     <= h_byte_d;
      h_load_q     <= h_load_d;
      h_off_q      <= h_off_d;
      h_regwen_q   <= h_regwen_d;
      h_ccwen_q    <= h_ccwen_d;
      h_misalign_q <= h_misalign_d;
    end
  end

  assign O_LOCK       = lock_q;
  assign O_PC         = pc_q;
  assign O_Opcode     = opc_q;
  assign O_IR         = ir_q;
  assign O_DestRegIdx = idx_q;
  assign O_DestValue  = dval_q;
  assign O_CCValue    = cc_q;
  assign O_MEM_Valid  = valid_q;
  assign O_RegWEn     = regwen_q;
  assign O_CCWEn      = ccwen_q;
  assign O_MemErr     = err_q;
  assign O_LEDR       = ledr_q;
  assign O_HEX        = hex_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed instruction stream, byte-addressed memory
// model with programmable ack latency, and a retirement scoreboard checked
// every cycle.

module tb_mem_stage;

  localparam int          ACK_TIMEOUT = 15;
  localparam logic [31:0] MMIO_BASE   = 32'hF000_0000;
  localparam logic [7:0]  OP_ADD = 8'h01, OP_LDB = 8'h20, OP_LDW = 8'h21,
                          OP_STB = 8'h22, OP_STW = 8'h23;

  logic        I_CLOCK = 1'b1, I_RESET_N = 1'b0, I_LOCK = 1'b0;
  logic [15:0] I_PC = '0;
  logic [7:0]  I_Opcode = '0;
  logic [31:0] I_IR = '0;
  logic [3:0]  I_DestRegIdx = '0;
  logic [31:0] I_DestValue = '0;
  logic [2:0]  I_CCValue = '0;
  logic        I_EX_Valid = 1'b0;
  logic [31:0] I_MARValue = '0, I_MDRValue = '0;
  logic        I_RegWEn = 1'b0, I_CCWEn = 1'b0;
  logic [31:0] I_DMemRdData = '0;
  logic        I_DMemAck = 1'b0;

  logic        O_LOCK;
  logic [7:0]  O_Opcode;
  logic [15:0] O_PC;
  logic [31:0] O_IR;
  logic [3:0]  O_DestRegIdx;
  logic [31:0] O_DestValue;
  logic [2:0]  O_CCValue;
  logic        O_MEM_Valid, O_RegWEn, O_CCWEn, O_RegWEn_Signal, O_CCWEn_Signal;
  logic        O_MEMStall, O_DMemReq, O_DMemWrEn, O_MemErr;
  logic [31:0] O_DMemAddr, O_DMemWrData;
  logic [3:0]  O_DMemByteEn;
  logic [9:0]  O_LEDR;
  logic [15:0] O_HEX;

  mem_stage #(
    .DATA_WIDTH(32), .MMIO_BASE(MMIO_BASE), .ACK_TIMEOUT(ACK_TIMEOUT),
    .PC_WIDTH(16), .OPCODE_WIDTH(8), .IR_WIDTH(32),
    .OP_LDB(OP_LDB), .OP_LDW(OP_LDW), .OP_STB(OP_STB), .OP_STW(OP_STW)
  ) dut (
    .I_CLOCK(I_CLOCK), .I_RESET_N(I_RESET_N), .I_LOCK(I_LOCK), .I_PC(I_PC),
    .I_Opcode(I_Opcode), .I_IR(I_IR), .I_DestRegIdx(I_DestRegIdx),
    .I_DestValue(I_DestValue), .I_CCValue(I_CCValue), .I_EX_Valid(I_EX_Valid),
    .I_MARValue(I_MARValue), .I_MDRValue(I_MDRValue), .I_RegWEn(I_RegWEn),
    .I_CCWEn(I_CCWEn), .I_DMemRdData(I_DMemRdData), .I_DMemAck(I_DMemAck),
    .O_LOCK(O_LOCK), .O_Opcode(O_Opcode), .O_PC(O_PC), .O_IR(O_IR),
    .O_DestRegIdx(O_DestRegIdx), .O_DestValue(O_DestValue), .O_CCValue(O_CCValue),
    .O_MEM_Valid(O_MEM_Valid), .O_RegWEn(O_RegWEn), .O_CCWEn(O_CCWEn),
    .O_RegWEn_Signal(O_RegWEn_Signal), .O_CCWEn_Signal(O_CCWEn_Signal),
    .O_MEMStall(O_MEMStall), .O_DMemReq(O_DMemReq), .O_DMemAddr(O_DMemAddr),
    .O_DMemWrEn(O_DMemWrEn), .O_DMemByteEn(O_DMemByteEn),
    .O_DMemWrData(O_DMemWrData), .O_LEDR(O_LEDR), .O_HEX(O_HEX),
    .O_MemErr(O_MemErr)
  );

  always #5 I_CLOCK = ~I_CLOCK;

  typedef struct {
    logic [15:0] pc;
    logic [3:0]  idx;
    logic [31:0] dest;
    logic        rw, cw, err;
  } ret_t;

  ret_t        rq[$];
  logic [7:0]  mem_b[logic [31:0]];
  logic [9:0]  m_ledr = '0;
  logic [15:0] m_hex = '0;
  int          n_vec = 0, n_bad = 0;
  int          last_stall = 0;
  logic        chk_en = 1'b0;
  logic [15:0] pc_ctr = 16'h0040;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    return mem_b.exists(a) ? mem_b[a] : 8'h00;
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] wa);
    return {rd_byte(wa + 3), rd_byte(wa + 2), rd_byte(wa + 1), rd_byte(wa)};
  endfunction

  function automatic logic [31:0] mmio_load(input logic [31:0] wa, input logic byteop,
                                            input logic [1:0] off);
    logic [31:0] v;
    if (wa == MMIO_BASE) v = {22'b0, m_ledr};
    else if (wa == MMIO_BASE + 4) v = {16'b0, m_hex};
    else v = 32'h0;
    if (byteop) v = (v >> (8 * off)) & 32'hFF;
    return v;
  endfunction

  // Scoreboard: whatever the stage retired at the last negedge must match
  // the oldest expected retirement.
  always @(posedge I_CLOCK) begin
    if (chk_en) begin
      chk("ledr", {22'b0, O_LEDR}, {22'b0, m_ledr});
      chk("hex", {16'b0, O_HEX}, {16'b0, m_hex});
      if (O_MEM_Valid) begin
        if (rq.size() == 0) begin
          chk("unexpected_valid", {31'b0, O_MEM_Valid}, 32'h0);
        end else begin
          ret_t e;
          e = rq.pop_front();
          chk("pc", {16'b0, O_PC}, {16'b0, e.pc});
          chk("idx", {28'b0, O_DestRegIdx}, {28'b0, e.idx});
          chk("dest", O_DestValue, e.dest);
          chk("regwen", {31'b0, O_RegWEn}, {31'b0, e.rw});
          chk("ccwen", {31'b0, O_CCWEn}, {31'b0, e.cw});
          chk("memerr", {31'b0, O_MemErr}, {31'b0, e.err});
        end
      end else begin
        chk("memerr_idle", {31'b0, O_MemErr}, 32'h0);
        chk("regwen_idle", {31'b0, O_RegWEn}, 32'h0);
      end
    end
  end

  // ackd: request cycle (0-based) on which memory acks; -1 = never
  task automatic issue(input logic [7:0] op, input logic [31:0] mar, input logic [31:0] mdr,
                       input logic [31:0] dval, input logic [3:0] idx, input logic rw,
                       input logic cw, input logic v, input logic lk, input int ackd);
    logic        memop, mmio, ext, load, byteop, misal;
    logic [1:0]  off;
    logic [31:0] wa, exp_wd;
    logic [3:0]  exp_be;
    int          cyc, stalls;
    bit          done;
    ret_t        r;
    @(posedge I_CLOCK);
    pc_ctr = pc_ctr + 16'd4;
    I_Opcode = op; I_MARValue = mar; I_MDRValue = mdr; I_DestValue = dval;
    I_DestRegIdx = idx; I_RegWEn = rw; I_CCWEn = cw; I_EX_Valid = v; I_LOCK = lk;
    I_PC = pc_ctr; I_IR = {op, 24'h00_1234}; I_CCValue = 3'b010;
    load   = (op == OP_LDB) || (op == OP_LDW);
    byteop = (op == OP_LDB) || (op == OP_STB);
    memop  = lk && v && (load || op == OP_STB || op == OP_STW);
    mmio   = (mar >= MMIO_BASE);
    ext    = memop && !mmio;
    off    = mar[1:0];
    wa     = {mar[31:2], 2'b00};
    misal  = !byteop && (off != 2'b00);
    exp_be = byteop ? (4'b0001 << off) : 4'b1111;
    exp_wd = (op == OP_STB) ? {4{mdr[7:0]}} : mdr;
    cyc = 0; stalls = 0; done = 0;
    while (!done) begin
      I_DMemAck = ext && (ackd >= 0) && (cyc == ackd);
      I_DMemRdData = rd_word(wa);
      #1;
      chk("req", {31'b0, O_DMemReq}, {31'b0, ext});
      chk("stall", {31'b0, O_MEMStall}, {31'b0, ext && (ackd != 0)});
      chk("regwen_sig", {31'b0, O_RegWEn_Signal}, {31'b0, v && rw});
      if (ext) begin
        chk("addr", O_DMemAddr, wa);
        chk("byteen", {28'b0, O_DMemByteEn}, {28'b0, exp_be});
        chk("wren", {31'b0, O_DMemWrEn}, {31'b0, !load});
        if (!load) chk("wrdata", O_DMemWrData, exp_wd);
      end
      if (O_MEMStall) stalls++;
      if (!ext || I_DMemAck || cyc == ACK_TIMEOUT - 1) done = 1;
      else begin
        @(posedge I_CLOCK);
        cyc++;
      end
    end
    last_stall = stalls;
    if (lk && v) begin
      r.pc = pc_ctr; r.idx = idx; r.dest = dval; r.rw = rw; r.cw = cw; r.err = 1'b0;
      if (memop) begin
        r.rw  = rw && load;
        r.err = misal;
        if (mmio) begin
          if (load) r.dest = mmio_load(wa, byteop, off);
          else if (wa == MMIO_BASE) m_ledr = mdr[9:0];
          else if (wa == MMIO_BASE + 4) m_hex = mdr[15:0];
        end else if (!I_DMemAck) begin
          r.rw = 1'b0; r.cw = 1'b0; r.err = 1'b1;
        end else if (load) begin
          r.dest = byteop ? {24'b0, rd_byte(mar)} : rd_word(wa);
        end else if (byteop) begin
          mem_b[mar] = mdr[7:0];
        end else begin
          for (int i = 0; i < 4; i++) mem_b[wa + i] = mdr[8*i +: 8];
        end
      end
      rq.push_back(r);
    end
  endtask

  task automatic settle();
    @(negedge I_CLOCK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_b[32'h200] = 8'hDD; mem_b[32'h201] = 8'hCC;
    mem_b[32'h202] = 8'hBB; mem_b[32'h203] = 8'hAA;
    repeat (3) @(posedge I_CLOCK);
    #1;
    chk("rst_valid", {31'b0, O_MEM_Valid}, 32'h0);
    chk("rst_regwen", {31'b0, O_RegWEn}, 32'h0);
    chk("rst_ccwen", {31'b0, O_CCWEn}, 32'h0);
    chk("rst_lock", {31'b0, O_LOCK}, 32'h0);
    chk("rst_req", {31'b0, O_DMemReq}, 32'h0);
    chk("rst_err", {31'b0, O_MemErr}, 32'h0);
    chk("rst_ledr", {22'b0, O_LEDR}, 32'h0);
    chk("rst_hex", {16'b0, O_HEX}, 32'h0);
    chk("rst_dest", O_DestValue, 32'h0);
    chk("rst_idx", {28'b0, O_DestRegIdx}, 32'h0);
    I_RESET_N = 1'b1;
    chk_en = 1'b1;

    issue(OP_ADD, 32'h0, 32'h0, 32'h1234, 4'd3, 1, 1, 1, 1, -1);
    settle();
    chk("add_dest", O_DestValue, 32'h1234);
    chk("add_idx", {28'b0, O_DestRegIdx}, 32'h3);
    chk("add_valid", {31'b0, O_MEM_Valid}, 32'h1);
    chk("add_req", {31'b0, O_DMemReq}, 32'h0);

    issue(OP_STW, 32'h100, 32'hDEADBEEF, 32'h55, 4'd4, 1, 0, 1, 1, 2);
    chk("stw_stall_cycles", last_stall, 3);
    settle();
    chk("stw_valid", {31'b0, O_MEM_Valid}, 32'h1);
    chk("stw_regwen", {31'b0, O_RegWEn}, 32'h0);

    issue(OP_LDB, 32'h202, 32'h0, 32'h0, 4'd5, 1, 1, 1, 1, 0);
    chk("ldb_stall_cycles", last_stall, 0);
    settle();
    chk("ldb_dest", O_DestValue, 32'h0000_00BB);

    issue(OP_LDW, 32'h201, 32'h0, 32'h0, 4'd6, 1, 0, 1, 1, 0);
    settle();
    chk("ldw_mis_err", {31'b0, O_MemErr}, 32'h1);
    chk("ldw_mis_dest", O_DestValue, 32'hAABBCCDD);

    issue(OP_STB, 32'h103, 32'h0000_005A, 32'h0, 4'd0, 0, 0, 1, 1, 1);
    issue(OP_LDW, 32'h100, 32'h0, 32'h0, 4'd7, 1, 1, 1, 1, 3);
    settle();
    chk("ldw_after_stb", O_DestValue, 32'h5AAD_BEEF);

    issue(OP_STW, MMIO_BASE, 32'h0000_03FF, 32'h0, 4'd0, 0, 0, 1, 1, 0);
    settle();
    chk("mmio_ledr", {22'b0, O_LEDR}, 32'h3FF);
    issue(OP_LDW, MMIO_BASE, 32'h0, 32'h0, 4'd8, 1, 0, 1, 1, 0);
    settle();
    chk("mmio_ldw", O_DestValue, 32'h3FF);
    issue(OP_STW, MMIO_BASE + 4, 32'h1234_BEEF, 32'h0, 4'd0, 0, 0, 1, 1, 0);
    issue(OP_LDB, MMIO_BASE + 5, 32'h0, 32'h0, 4'd9, 1, 0, 1, 1, 0);
    settle();
    chk("mmio_ldb_hex", O_DestValue, 32'hBE);
    issue(OP_STW, MMIO_BASE + 16, 32'hFFFF_FFFF, 32'h0, 4'd0, 0, 0, 1, 1, 0);
    issue(OP_LDW, MMIO_BASE + 16, 32'h0, 32'h77, 4'd10, 1, 0, 1, 1, 0);

    issue(OP_LDW, 32'h200, 32'h0, 32'h0, 4'd11, 1, 1, 1, 0, 0);
    issue(OP_ADD, 32'h0, 32'h0, 32'h99, 4'd12, 1, 1, 0, 1, -1);

    issue(OP_LDW, 32'h204, 32'h0, 32'hCAFE, 4'd13, 1, 1, 1, 1, -1);
    chk("timeout_stall_cycles", last_stall, ACK_TIMEOUT);
    settle();
    chk("timeout_err", {31'b0, O_MemErr}, 32'h1);
    chk("timeout_regwen", {31'b0, O_RegWEn}, 32'h0);
    chk("timeout_valid", {31'b0, O_MEM_Valid}, 32'h1);
    issue(OP_ADD, 32'h0, 32'h0, 32'h0, 4'd0, 0, 0, 0, 1, -1);

    // Reset while an access is outstanding
    @(posedge I_CLOCK);
    I_Opcode = OP_LDW; I_MARValue = 32'h300; I_EX_Valid = 1'b1; I_LOCK = 1'b1;
    I_DMemAck = 1'b0; I_RegWEn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rstwait_stall", {31'b0, O_MEMStall}, 32'h1);
      @(posedge I_CLOCK);
    end
    chk_en = 1'b0;
    I_RESET_N = 1'b0;
    I_EX_Valid = 1'b0;
    settle();
    chk("rstwait_req", {31'b0, O_DMemReq}, 32'h0);
    chk("rstwait_stall_off", {31'b0, O_MEMStall}, 32'h0);
    chk("rstwait_valid", {31'b0, O_MEM_Valid}, 32'h0);
    @(posedge I_CLOCK);
    I_RESET_N = 1'b1;
    m_ledr = '0; m_hex = '0;
    chk_en = 1'b1;

    issue(OP_ADD, 32'h0, 32'h0, 32'h4321, 4'd2, 1, 0, 1, 1, -1);
    issue(OP_ADD, 32'h0, 32'h0, 32'h0, 4'd0, 0, 0, 0, 1, -1);
    repeat (2) @(posedge I_CLOCK);
    #1;
    chk("queue_drained", rq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
